fetch_unit: RTL

Instruction-fetch stage of the five-stage RISC-V pipeline. Owns the program counter, issues instruction-memory reads over a request/response handshake, and presents InstrF/PCF/PCPlus4F to the IF/ID pipeline register. Handles hazard-unit stalls (StallF) and taken-branch/jump redirects from Execute (PCSrcE/PCTargetE). Signals a bubble (ValidF=0) whenever no fetched instruction is available.

---
 rtl/fetch_unit.sv | 54 +++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, the imem request/response
// handshake, stall/redirect handling and the InstrF/PCF/PCPlus4F/ValidF outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;
  state_t state;
  logic [31:0] pc, buffer;
  logic rsp, adv, hs;
  always_comb begin
    rsp = state == WAIT && imem_rvalid;
    ValidF = rsp || state == HOLD;
    InstrF = state == HOLD ? buffer : rsp ? imem_rdata : NOP_INSTR;
    adv = ValidF && !StallF && !PCSrcE;
    imem_req = reset && !PCSrcE && (state == FETCH || (rsp && adv));
    imem_addr = state == WAIT ? pc + 32'd4 : pc;
    hs = imem_req && imem_ready;
    PCF = pc;
    PCPlus4F = pc + 32'd4;
  end
  // rvalid outside WAIT/DROP is a protocol error and deliberately ignored
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      buffer <= '0;
    end else begin
      pc <= PCSrcE ? PCTargetE & 32'hFFFF_FFFC : adv ? pc + 32'd4 : pc;
      if (rsp && StallF && !PCSrcE) buffer <= imem_rdata;
      case (state)
        FETCH: state <= hs ? WAIT : FETCH;
        WAIT:  state <= rsp ? (adv && hs ? WAIT : StallF && !PCSrcE ? HOLD : FETCH)
                            : PCSrcE ? DROP : WAIT;
        HOLD:  state <= adv || PCSrcE ? FETCH : HOLD;
        DROP:  state <= imem_rvalid ? FETCH : DROP;
      endcase
    end
endmodule
